// File: rtl/mem_responder_pkg.sv
// Shared memory-map definitions for the responder and the cache: request
// encoding, I/O window offsets and a request classifier.
package mem_responder_pkg;

   localparam logic        READ_SIGNAL     = 1'b1;
   localparam logic        WRITE_SIGNAL    = 1'b0;
   localparam logic [31:0] NULL_PTR        = 32'h0000_0000;
   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
   localparam logic [31:0] IO_TX_OFS       = 32'h0000_0000;
   localparam logic [31:0] IO_HALT_OFS     = 32'h0000_0004;

   typedef enum logic [1:0] {
      REQ_RAM_RD,
      REQ_RAM_WR,
      REQ_IO_RD,
      REQ_IO_WR
   } req_kind_e;

   function automatic req_kind_e classify(input logic [31:0] addr,
                                          input logic [31:0] io_base,
                                          input logic        r_nw);
      if (addr < io_base)
         return (r_nw == READ_SIGNAL) ? REQ_RAM_RD : REQ_RAM_WR;
      return (r_nw == READ_SIGNAL) ? REQ_IO_RD : REQ_IO_WR;
   endfunction

endpackage

// File: rtl/mem_responder_tx_fifo.sv
// Tx byte buffer. With IO_TX_FIFO_EN defined it is a DEPTH-entry FIFO;
// otherwise a single holding register where a new push overwrites the byte.
module tx_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [7:0]    din_i,
   output logic [7:0]    dout_o,
   output logic          full_o,
   output logic [CW-1:0] count_o,
   output logic          overflow_o
);

`ifdef IO_TX_FIFO_EN
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          is_full, do_push, do_pop;

   always_comb begin
      is_full  = (cnt_q == CW'(DEPTH));
      do_pop   = pop_i && (cnt_q != '0);
      // a pop frees the slot this same cycle, so a full buffer still accepts
      do_push  = push_i && (!is_full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop)
         cnt_d = cnt_q - CW'(1);
      ovf_d    = ovf_q | (push_i && is_full && !do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push)
         mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o     = mem_q[rd_ptr_q];
   assign full_o     = (cnt_q >= CW'(DEPTH - 1));
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;
`else
   logic [7:0] hold_q, hold_d;
   logic       vld_q, vld_d;
   logic       ovf_q, ovf_d;

   always_comb begin
      hold_d = hold_q;
      vld_d  = vld_q;
      if (push_i) begin
         hold_d = din_i;
         vld_d  = 1'b1;
      end else if (pop_i && vld_q) begin
         vld_d  = 1'b0;
      end
      ovf_d  = ovf_q | (push_i && vld_q && !pop_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= 8'h00;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
      end
   end

   assign dout_o     = hold_q;
   assign full_o     = vld_q;
   assign count_o    = CW'(vld_q);
   assign overflow_o = ovf_q;
`endif

endmodule

// File: rtl/mem_responder.sv
// Byte RAM plus I/O window (tx byte port, halt flag) answering one request
// per enabled cycle. IO_TX_FIFO_EN selects the deep tx FIFO over a single register.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH = 17,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] addr_in,
   input  logic        r_nw_in,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        io_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt,
   output logic        tx_overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]            ram_q [2**ADDR_WIDTH];
   logic [7:0]            data_out_q, data_out_d;
   logic                  halt_q, halt_d;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           io_ofs;
   req_kind_e             kind;
   logic                  io_wr, push;
   logic [CW-1:0]         tx_count;

   assign idx = addr_in[ADDR_WIDTH-1:0];

   always_comb begin
      kind       = classify(addr_in, IO_BASE, r_nw_in);
      io_ofs     = (kind == REQ_IO_RD || kind == REQ_IO_WR) ? addr_in - IO_BASE : NULL_PTR;
      io_wr      = rdy && (kind == REQ_IO_WR);
      push       = io_wr && (io_ofs == IO_TX_OFS);
      halt_d     = halt_q | (io_wr && (io_ofs == IO_HALT_OFS));
      data_out_d = data_out_q;
      if (rdy) begin
         if (kind == REQ_RAM_RD)
            data_out_d = ram_q[idx];
         else if (kind == REQ_IO_RD)
            data_out_d = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= 8'h00;
         halt_q     <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         halt_q     <= halt_d;
      end
   end

   // RAM is deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (!rst && rdy && kind == REQ_RAM_WR)
         ram_q[idx] <= data_in;
   end

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_tx_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .pop_i      (tx_ready),
      .din_i      (data_in),
      .dout_o     (tx_data),
      .full_o     (io_full),
      .count_o    (tx_count),
      .overflow_o (tx_overflow)
   );

   assign tx_valid = (tx_count != '0);
   assign data_out = data_out_q;
   assign halt     = halt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected read/tx bytes are queued by the
// stimulus and consumed by a monitor. IO_TX_FIFO_EN selects the tx scenarios.
`timescale 1ns/1ps
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, r_nw_in, tx_ready;
   logic [31:0] addr_in;
   logic [7:0]  data_in;
   wire  [7:0]  data_out, tx_data;
   wire         io_full, tx_valid, halt, tx_overflow;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  rd_exp[$];
   logic [7:0]  tx_exp[$];
   logic        chk_rd  = 1'b0;
   logic        rd_pend = 1'b0;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .addr_in     (addr_in),
      .r_nw_in     (r_nw_in),
      .data_in     (data_in),
      .data_out    (data_out),
      .io_full     (io_full),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .halt        (halt),
      .tx_overflow (tx_overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) rd_pend <= chk_rd && rdy && !rst;

   always @(negedge clk) begin
      logic [7:0] e;
      if (rd_pend) begin
         if (rd_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: data_out %h, no read expected", data_out);
         end else begin
            e = rd_exp.pop_front();
            check("rd_data", {24'h0, data_out}, {24'h0, e});
         end
      end
      if (tx_valid && tx_ready && !rst) begin
         if (tx_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: tx_data %h, no byte expected", tx_data);
         end else begin
            e = tx_exp.pop_front();
            check("tx_data", {24'h0, tx_data}, {24'h0, e});
         end
      end
   end

   task automatic req(input logic [31:0] a, input logic rnw, input logic [7:0] d,
                      input logic en, input logic chk, input logic [7:0] e);
      addr_in = a; r_nw_in = rnw; data_in = d; rdy = en; chk_rd = chk;
      if (chk) rd_exp.push_back(e);
      @(posedge clk); #1;
      chk_rd = 1'b0; rdy = 1'b1; addr_in = NULL_PTR; r_nw_in = READ_SIGNAL; data_in = 8'h00;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      req(a, WRITE_SIGNAL, d, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] e);
      req(a, READ_SIGNAL, 8'h00, 1'b1, 1'b1, e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic apply_reset();
      rst = 1'b1; chk_rd = 1'b0;
      idle(2);
      tx_exp.delete();
      check("rst_data_out", {24'h0, data_out}, 32'h0);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_halt", {31'h0, halt}, 32'h0);
      check("rst_tx_overflow", {31'h0, tx_overflow}, 32'h0);
      check("rst_io_full", {31'h0, io_full}, 32'h0);
      rst = 1'b0;
   endtask

   task automatic wait_tx_empty(input int budget);
      int k = 0;
      while (tx_exp.size() != 0 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      n_checks++;
      if (tx_exp.size() != 0) begin
         n_fail++;
         $display("FAIL tx_drain_timeout: %0d bytes left after %0d cycles, expected 0", tx_exp.size(), k);
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; addr_in = NULL_PTR; r_nw_in = READ_SIGNAL;
      data_in = 8'h00; tx_ready = 1'b0;
      apply_reset();

      // RAM: basic, write-then-read, aliasing
      wr(32'h0000_0010, 8'hA5);  rd(32'h0000_0010, 8'hA5);
      wr(32'h0000_0020, 8'h3C);  rd(32'h0000_0020, 8'h3C);
      wr(32'h0002_0000, 8'h11);  rd(32'h0000_0000, 8'h11);
      rd(32'h0002_0000, 8'h11);

      // rdy low blocks the write and freezes data_out
      wr(32'h0000_0040, 8'h77);  rd(32'h0000_0040, 8'h77);
      req(32'h0000_0040, WRITE_SIGNAL, 8'h5A, 1'b0, 1'b0, 8'h00);
      check("rdy0_data_out_hold", {24'h0, data_out}, 32'h77);
      rd(32'h0000_0040, 8'h77);

      // I/O accesses leave RAM alone; I/O reads return zero
      wr(32'h0001_0008, 8'h22);
      wr(32'h0003_0008, 8'h99);
      check("io_other_no_push", {31'h0, tx_valid}, 32'h0);
      rd(32'h0001_0008, 8'h22);
      rd(32'h0003_0000, 8'h00);
      req(32'h0003_0000, WRITE_SIGNAL, 8'hCC, 1'b0, 1'b0, 8'h00);
      check("rdy0_no_push", {31'h0, tx_valid}, 32'h0);

`ifdef IO_TX_FIFO_EN
      tx_ready = 1'b0;
      addr_in = 32'h0003_0000; r_nw_in = WRITE_SIGNAL; data_in = 8'h01; rdy = 1'b1;
      tx_exp.push_back(8'h01);
      #1 check("tx_no_passthru", {31'h0, tx_valid}, 32'h0);
      @(posedge clk); #1;
      check("tx_valid_rise", {31'h0, tx_valid}, 32'h1);
      for (int i = 2; i <= 8; i++) begin
         tx_exp.push_back(8'(i));
         wr(32'h0003_0000, 8'(i));
         if (i == 6) check("io_full_after6", {31'h0, io_full}, 32'h0);
         if (i == 7) check("io_full_after7", {31'h0, io_full}, 32'h1);
         if (i == 8) check("no_ovf_after8", {31'h0, tx_overflow}, 32'h0);
      end
      wr(32'h0003_0000, 8'h09);
      check("ovf_after9", {31'h0, tx_overflow}, 32'h1);
      check("io_full_when_full", {31'h0, io_full}, 32'h1);
      tx_ready = 1'b1; rdy = 1'b0;
      wait_tx_empty(40);
      rdy = 1'b1;
      check("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
      check("io_full_drained", {31'h0, io_full}, 32'h0);

      apply_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tx_exp.push_back(8'(8'h21 + i));
         wr(32'h0003_0000, 8'(8'h21 + i));
      end
      tx_ready = 1'b1;
      tx_exp.push_back(8'h29);
      wr(32'h0003_0000, 8'h29);
      check("full_pushpop_no_ovf", {31'h0, tx_overflow}, 32'h0);
      check("full_pushpop_io_full", {31'h0, io_full}, 32'h1);
      wait_tx_empty(40);
      check("tx_valid_drained2", {31'h0, tx_valid}, 32'h0);
`else
      tx_ready = 1'b0;
      addr_in = 32'h0003_0000; r_nw_in = WRITE_SIGNAL; data_in = 8'h41; rdy = 1'b1;
      #1 check("tx_no_passthru", {31'h0, tx_valid}, 32'h0);
      @(posedge clk); #1;
      check("tx_valid_rise", {31'h0, tx_valid}, 32'h1);
      check("io_full_hold", {31'h0, io_full}, 32'h1);
      check("no_ovf_first", {31'h0, tx_overflow}, 32'h0);
      tx_exp.push_back(8'h42);
      wr(32'h0003_0000, 8'h42);
      check("hold_overwrite_data", {24'h0, tx_data}, 32'h42);
      check("hold_overwrite_ovf", {31'h0, tx_overflow}, 32'h1);
      tx_ready = 1'b1;
      wait_tx_empty(10);
      check("tx_valid_drained", {31'h0, tx_valid}, 32'h0);

      apply_reset();
      tx_ready = 1'b0;
      tx_exp.push_back(8'h50);
      wr(32'h0003_0000, 8'h50);
      tx_ready = 1'b1;
      tx_exp.push_back(8'h51);
      wr(32'h0003_0000, 8'h51);
      check("hold_pushpop_no_ovf", {31'h0, tx_overflow}, 32'h0);
      wait_tx_empty(10);
      check("tx_valid_drained2", {31'h0, tx_valid}, 32'h0);
`endif

      // halt is sticky; reset clears it, discards tx bytes and beats a request
      tx_ready = 1'b0;
      req(32'h0003_0004, WRITE_SIGNAL, 8'h00, 1'b0, 1'b0, 8'h00);
      check("halt_rdy0", {31'h0, halt}, 32'h0);
      wr(32'h0003_0004, 8'h00);
      check("halt_set", {31'h0, halt}, 32'h1);
      idle(3);
      check("halt_sticky", {31'h0, halt}, 32'h1);
      wr(32'h0003_0000, 8'h77);
      check("tx_pending", {31'h0, tx_valid}, 32'h1);
      rd(32'h0000_0010, 8'hA5);
      rst = 1'b1; addr_in = 32'h0000_0010; r_nw_in = WRITE_SIGNAL; data_in = 8'hFF; rdy = 1'b1;
      @(posedge clk); #1;
      tx_exp.delete();
      check("rst2_data_out", {24'h0, data_out}, 32'h0);
      check("rst2_halt", {31'h0, halt}, 32'h0);
      check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst2_io_full", {31'h0, io_full}, 32'h0);
      rst = 1'b0; addr_in = NULL_PTR; r_nw_in = READ_SIGNAL; data_in = 8'h00;
      rd(32'h0000_0010, 8'hA5);
      idle(2);

      check("rd_queue_empty", rd_exp.size(), 32'h0);
      check("tx_queue_empty", tx_exp.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
